// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one instruction word per Start
// over a req/ack handshake and strobes it into the IR datapath.
module instr_fetch_unit #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int PC_INC  = 2,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start,
    input  logic              PCW,
    input  logic [ADDR_W-1:0] PCIn,
    input  logic              MemAck,
    input  logic [DATA_W-1:0] MemRData,
    output logic              MemReq,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MD,
    output logic              IW,
    output logic [ADDR_W-1:0] PC,
    output logic              Busy,
    output logic              Done,
    output logic              FetchErr
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  TO_C    = CNT_W'(TIMEOUT);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_ISSUE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] md_q, md_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;

    assign cnt_inc = cnt_q + 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            md_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            md_q    <= md_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        md_d    = md_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (PCW) pc_d = PCIn;
                if (Start) state_d = S_REQ;
            end
            S_REQ: begin
                cnt_d = cnt_inc;
                // An ack on the timeout edge still counts as a good fetch
                if (MemAck) begin
                    md_d    = MemRData;
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end else if (TIMEOUT != 0 && cnt_inc == TO_C) begin
                    cnt_d   = '0;
                    state_d = S_ERR;
                end
            end
            S_ISSUE: begin
                pc_d    = pc_q + PC_STEP;
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign MemReq   = (state_q == S_REQ);
    assign MemAddr  = pc_q;
    assign MD       = md_q;
    assign PC       = pc_q;
    assign IW       = (state_q == S_ISSUE);
    assign Done     = (state_q == S_ISSUE);
    assign FetchErr = (state_q == S_ERR);
    assign Busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
// Inputs driven and outputs sampled 1ns after each rising edge.
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Start;
    logic        PCW;
    logic [15:0] PCIn;
    logic        MemAck;
    logic [15:0] MemRData;
    logic        MemReq;
    logic [15:0] MemAddr;
    logic [15:0] MD;
    logic        IW;
    logic [15:0] PC;
    logic        Busy;
    logic        Done;
    logic        FetchErr;

    int n_chk  = 0;
    int n_pass = 0;
    int iw_cnt = 0;
    int err_cnt = 0;

    instr_fetch_unit #(
        .ADDR_W (16),
        .DATA_W (16),
        .PC_INC (2),
        .TIMEOUT(15)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .Start   (Start),
        .PCW     (PCW),
        .PCIn    (PCIn),
        .MemAck  (MemAck),
        .MemRData(MemRData),
        .MemReq  (MemReq),
        .MemAddr (MemAddr),
        .MD      (MD),
        .IW      (IW),
        .PC      (PC),
        .Busy    (Busy),
        .Done    (Done),
        .FetchErr(FetchErr)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (IW === 1'b1) iw_cnt++;
        if (FetchErr === 1'b1) err_cnt++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic run_fetch(input string tag, input logic [15:0] data,
                             input int waits, input logic pcw,
                             input logic [15:0] pcin,
                             input logic [15:0] exp_addr,
                             input logic [15:0] exp_pc);
        int iw0;
        int err0;
        bit req_ok;
        iw0 = iw_cnt;
        err0 = err_cnt;
        req_ok = 1'b1;
        Start = 1'b1;
        PCW = pcw;
        PCIn = pcin;
        tick();
        Start = 1'b0;
        PCW = 1'b0;
        for (int i = 0; i < waits; i++) begin
            if (!(MemReq === 1'b1 && MemAddr === exp_addr)) req_ok = 1'b0;
            tick();
        end
        if (!(MemReq === 1'b1 && MemAddr === exp_addr)) req_ok = 1'b0;
        MemAck = 1'b1;
        MemRData = data;
        tick();
        MemAck = 1'b0;
        MemRData = 16'h0;
        check({tag, ".req"}, 32'(req_ok), 32'd1);
        check({tag, ".iw_done_req"}, {IW, Done, MemReq}, 3'b110);
        check({tag, ".md"}, MD, data);
        tick();
        check({tag, ".pc"}, PC, exp_pc);
        check({tag, ".busy_iw"}, {Busy, IW}, 2'b00);
        check({tag, ".n_iw"}, iw_cnt - iw0, 1);
        check({tag, ".n_err"}, err_cnt - err0, 0);
    endtask

    initial begin
        int iw0;
        int err0;
        int req_cycles;
        RST = 1'b1;
        Start = 1'b0;
        PCW = 1'b0;
        PCIn = 16'h0;
        MemAck = 1'b0;
        MemRData = 16'h0;
        tick();
        tick();
        check("rst.pc_md", {PC, MD}, 32'h0);
        check("rst.outs", {MemReq, IW, Done, FetchErr, Busy}, 5'b0);
        check("rst.addr", MemAddr, 16'h0);
        RST = 1'b0;
        tick();

        run_fetch("f1", 16'h0127, 1, 1'b0, 16'h0, 16'h0000, 16'h0002);

        PCW = 1'b1;
        PCIn = 16'h0040;
        tick();
        PCW = 1'b0;
        check("pcw.pc", PC, 16'h0040);
        check("pcw.busy", Busy, 1'b0);
        run_fetch("f2", 16'hE017, 3, 1'b0, 16'h0, 16'h0040, 16'h0042);
        run_fetch("f3", 16'h5A5A, 2, 1'b1, 16'h0100, 16'h0100, 16'h0102);

        PCW = 1'b1;
        PCIn = 16'h0000;
        tick();
        PCW = 1'b0;
        iw0 = iw_cnt;
        run_fetch("b2b1", 16'hD017, 0, 1'b0, 16'h0, 16'h0000, 16'h0002);
        run_fetch("b2b2", 16'h001F, 0, 1'b0, 16'h0, 16'h0002, 16'h0004);
        check("b2b.n_iw", iw_cnt - iw0, 2);
        MemAck = 1'b1;
        MemRData = 16'hFFFF;
        tick();
        MemAck = 1'b0;
        tick();
        check("spur.md_pc", {MD, PC}, {16'h001F, 16'h0004});
        check("spur.busy", Busy, 1'b0);
        check("spur.n_iw", iw_cnt - iw0, 2);

        iw0 = iw_cnt;
        err0 = err_cnt;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        req_cycles = 0;
        while (MemReq === 1'b1 && req_cycles < 40) begin
            req_cycles++;
            tick();
        end
        check("to.req_cycles", req_cycles, 15);
        check("to.err_busy", {FetchErr, IW, Busy}, 3'b101);
        tick();
        check("to.idle", {FetchErr, Busy}, 2'b00);
        check("to.pc_md", {PC, MD}, {16'h0004, 16'h001F});
        check("to.n_err", err_cnt - err0, 1);
        check("to.n_iw", iw_cnt - iw0, 0);

        run_fetch("ack15", 16'h1234, 14, 1'b0, 16'h0, 16'h0004, 16'h0006);

        PCW = 1'b1;
        PCIn = 16'hFFFE;
        tick();
        PCW = 1'b0;
        Start = 1'b1;
        tick();
        PCW = 1'b1;
        PCIn = 16'h5555;
        tick();
        check("busy.addr_pc", {MemAddr, PC}, {16'hFFFE, 16'hFFFE});
        check("busy.req", MemReq, 1'b1);
        MemAck = 1'b1;
        MemRData = 16'hABCD;
        tick();
        Start = 1'b0;
        PCW = 1'b0;
        MemAck = 1'b0;
        check("wrap.iw_md", {IW, MD}, {1'b1, 16'hABCD});
        tick();
        check("wrap.pc", PC, 16'h0000);
        tick();
        check("wrap.noqueue", {Busy, MemReq}, 2'b00);

        iw0 = iw_cnt;
        PCW = 1'b1;
        PCIn = 16'h0200;
        tick();
        PCW = 1'b0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("rreq.outs", {MemReq, Busy, IW}, 3'b000);
        check("rreq.pc_md", {PC, MD}, 32'h0);
        MemAck = 1'b1;
        MemRData = 16'h7777;
        tick();
        MemAck = 1'b0;
        tick();
        check("rreq.late_ack", {MD, PC}, 32'h0);
        check("rreq.n_iw", iw_cnt - iw0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer side of the instruction-register load path: owns the PC and fetches 16-bit instruction words from memory over a req/ack handshake.
- Drives MD and a one-cycle IW strobe into the IR/register-file datapath.
- Started by the control unit once per instruction; reports completion via Done and fetch timeouts via FetchErr.

Parameters:
- ADDR_W, 16, PC and memory address width.
- DATA_W, 16, instruction word width.
- PC_INC, 2, amount added to PC after each successful fetch (byte-addressed memory).
- TIMEOUT, 15, max cycles in REQ waiting for MemAck; 0 disables the timeout.

Ports:
- CLK  in  1  system clock, all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- Start  in  1  request one instruction fetch; sampled only in IDLE.
- PCW  in  1  load PC from PCIn; honoured only in IDLE.
- PCIn  in  ADDR_W  new PC value (jump/branch target).
- MemAck  in  1  memory response valid; MemRData valid in the same cycle.
- MemRData  in  DATA_W  memory read data.
- MemReq  out  1  read request; held high until ack or timeout.
- MemAddr  out  ADDR_W  read address, equals PC while MemReq=1.
- MD  out  DATA_W  captured instruction word to IR.
- IW  out  1  IR write strobe, exactly one cycle per successful fetch.
- PC  out  ADDR_W  current program counter.
- Busy  out  1  high in any state other than IDLE.
- Done  out  1  one-cycle pulse, coincident with IW.
- FetchErr  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset: state=IDLE, PC=0, MD=0, MemReq=0, MemAddr=0, IW=0, Done=0, FetchErr=0, Busy=0, timeout counter=0. Reset in any state aborts the fetch immediately; MemReq drops the next edge. No IW or PC update for the aborted fetch.
- States: IDLE, REQ, ISSUE, ERR.
- IDLE:
  - PCW=1 loads PC<=PCIn.
  - Start=1 moves to REQ.
  - Start and PCW in the same cycle: PC<=PCIn and the fetch uses PCIn as its address.
- REQ:
  - MemReq=1, MemAddr=PC; the counter increments each cycle.
  - MemAck=1 at an edge: MD<=MemRData, counter cleared, go to ISSUE.
  - Counter reaching TIMEOUT with no ack (TIMEOUT≠0): go to ERR.
  - Ack on the same edge that the count reaches TIMEOUT: the ack wins.
- ISSUE: IW=1, Done=1, MemReq=0, PC<=PC+PC_INC (modulo 2^ADDR_W, wraps 0xFFFE→0x0000 with PC_INC=2). Then IDLE.
- ERR: FetchErr=1, MemReq=0, PC and MD unchanged. Then IDLE.
- Ignored inputs:
  - Start and PCW are ignored while Busy; no queuing.
  - MemAck outside REQ is ignored.
- Latency: Start sampled at edge n puts MemReq high during cycle n+1. Ack sampled at edge n+k gives IW/Done high during cycle n+k+1 and Busy=0 from n+k+2. Minimum Start-to-IW is 2 cycles.
- MD holds its value between fetches. IW rises in the same cycle MD is already stable.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset then Start with MemAck returned 1 cycle after MemReq and MemRData=16'h0127: MemAddr=0x0000, MD=0x0127, one IW/Done pulse, PC=0x0002, Busy low afterward.
- PCW=1 with PCIn=16'h0040, then Start; memory returns 16'hE017 after 3 wait cycles: MemAddr=0x0040 held throughout, MD=0xE017, PC=0x0042. Repeat with Start and PCW in the same cycle and PCIn=0x0100: address is 0x0100 and PC ends at 0x0102.
- Back-to-back fetches of 16'hD017 and 16'h001F: IW pulses exactly twice, PC advances 0→2→4, and a spurious MemAck in IDLE causes no change.
- MemAck withheld with TIMEOUT=15: MemReq stays high for 15 cycles, then one FetchErr pulse, no IW, PC unchanged. Ack on the 15th cycle gives a normal fetch with no FetchErr.
- PCIn=16'hFFFE, fetch completes: PC wraps to 0x0000. Start or PCW asserted while Busy: no effect on PC or on the fetch in progress.
- RST asserted mid-REQ: MemReq, Busy and IW are low after the next edge, PC=0, MD=0, and a later MemAck is ignored.
